// File: rtl/tempsense_sar_ctrl.sv
// Successive-approximation controller for the delay-line temperature sensors:
// MSB-first search per conversion, 2**N_AVG averaging, masked channel scan.
//
// state   | meaning
// IDLE    | waiting for i_start with a non-zero mask
// PRE     | sensor precharge, DAC at full scale
// TRANS   | precharge released, DAC at zero
// MEAS    | DAC at trial code
// EVAL    | DAC at trial code, delay line sampled
// OUT     | averaged result presented, waiting for i_ready
// GAP     | idle interval before the next continuous scan
module tempsense_sar_ctrl #(
  parameter int N_VDAC     = 6,
  parameter int N_CH       = 2,
  parameter int N_AVG      = 2,
  parameter int GAP_CYCLES = 1024,
  parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_cont,
  input  logic [N_CH-1:0]   i_ch_mask,
  input  logic [N_CH-1:0]   i_tempdelay,
  output logic [N_VDAC-1:0] o_dac_data,
  output logic [N_CH-1:0]   o_dac_en,
  output logic              o_precharge_n,
  output logic [N_VDAC-1:0] o_res,
  output logic [CH_W-1:0]   o_res_ch,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy
);

  localparam int KW    = (N_VDAC > 1) ? $clog2(N_VDAC) : 1;
  localparam int ACC_W = N_VDAC + N_AVG;
  localparam int CNT_W = N_AVG + 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'((1 << N_AVG) - 1);
  localparam logic [KW-1:0]     MSB_K    = KW'(N_VDAC - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_TRANS, S_MEAS, S_EVAL, S_OUT, S_GAP
  } state_t;

  state_t            state;
  logic [N_CH-1:0]   mask;
  logic [CH_W-1:0]   ch;
  logic [N_VDAC-1:0] code;
  logic [KW-1:0]     bit_k;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic [CH_W-1:0]   first_ch;
  logic [CH_W-1:0]   next_ch;
  logic              next_found;
  logic [N_VDAC-1:0] trial;
  logic [N_VDAC-1:0] code_upd;
  logic [ACC_W-1:0]  acc_upd;
  logic              td_sel;

  always_comb begin
    first_ch   = '0;
    next_ch    = '0;
    next_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_ch_mask[i]) first_ch = CH_W'(i);
      if (mask[i] && (CH_W'(i) > ch)) begin
        next_found = 1'b1;
        next_ch    = CH_W'(i);
      end
    end
  end

  // o_dac_en is one-hot on the active channel during EVAL, so it selects the delay line
  assign td_sel   = |(i_tempdelay & o_dac_en);
  assign trial    = code | (N_VDAC'(1) << bit_k);
  assign code_upd = td_sel ? trial : code;
  assign acc_upd  = acc + ACC_W'(code_upd);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      mask          <= '0;
      ch            <= '0;
      code          <= '0;
      bit_k         <= MSB_K;
      acc           <= '0;
      cnt           <= '0;
      gap_cnt       <= '0;
      o_dac_data    <= '1;
      o_dac_en      <= '0;
      o_precharge_n <= 1'b0;
      o_res         <= '0;
      o_res_ch      <= '0;
      o_valid       <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start && (|i_ch_mask)) begin
            mask     <= i_ch_mask;
            ch       <= first_ch;
            code     <= '0;
            acc      <= '0;
            cnt      <= '0;
            bit_k    <= MSB_K;
            o_dac_en <= N_CH'(1) << first_ch;
            o_busy   <= 1'b1;
            state    <= S_PRE;
          end
        end
        S_PRE: begin
          o_dac_data    <= '0;
          o_precharge_n <= 1'b1;
          state         <= S_TRANS;
        end
        S_TRANS: begin
          o_dac_data <= trial;
          state      <= S_MEAS;
        end
        S_MEAS: state <= S_EVAL;
        S_EVAL: begin
          o_dac_data    <= '1;
          o_precharge_n <= 1'b0;
          if (bit_k != '0) begin
            code  <= code_upd;
            bit_k <= bit_k - 1'b1;
            state <= S_PRE;
          end else begin
            code  <= '0;
            bit_k <= MSB_K;
            acc   <= acc_upd;
            if (cnt == LAST_CNT) begin
              cnt      <= '0;
              o_res    <= N_VDAC'(acc_upd >> N_AVG);
              o_res_ch <= ch;
              o_valid  <= 1'b1;
              o_dac_en <= '0;
              state    <= S_OUT;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= S_PRE;
            end
          end
        end
        S_OUT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            if (next_found) begin
              ch       <= next_ch;
              acc      <= '0;
              o_dac_en <= N_CH'(1) << next_ch;
              state    <= S_PRE;
            end else if (i_cont) begin
              gap_cnt <= GAP_LOAD;
              state   <= S_GAP;
            end else begin
              o_busy <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (!i_cont) begin
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (|i_ch_mask) begin
            mask     <= i_ch_mask;
            ch       <= first_ch;
            code     <= '0;
            acc      <= '0;
            cnt      <= '0;
            bit_k    <= MSB_K;
            o_dac_en <= N_CH'(1) << first_ch;
            state    <= S_PRE;
          end else begin
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tempsense_sar_ctrl.sv
// Bench for tempsense_sar_ctrl: threshold-based sensor model, table vectors,
// random scans against an averaged-threshold reference, and timing corners.
module tb_tempsense_sar_ctrl;

  localparam int NV = 6;
  localparam int NC = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_start, i_cont, i_ready;
  logic [NC-1:0] i_ch_mask, i_tempdelay;
  logic [NV-1:0] o_dac_data, o_res;
  logic [NC-1:0] o_dac_en;
  logic          o_precharge_n, o_res_ch, o_valid, o_busy;

  tempsense_sar_ctrl #(.N_VDAC(NV), .N_CH(NC), .N_AVG(2), .GAP_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_cont(i_cont),
    .i_ch_mask(i_ch_mask), .i_tempdelay(i_tempdelay), .o_dac_data(o_dac_data),
    .o_dac_en(o_dac_en), .o_precharge_n(o_precharge_n), .o_res(o_res),
    .o_res_ch(o_res_ch), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // Sensor model: delay line reports 1 while the DAC code is at or below the
  // threshold of the conversion in progress (conversion = TRANS count / NV).
  logic [3:0][5:0] thr_cur [NC];
  int              trans_cnt [NC];
  int              base [NC];
  logic [NV-1:0]   prev_dac = '1;
  logic [NV-1:0]   trial_log [$];

  always @(negedge clk) begin
    if (o_precharge_n && o_dac_data == '0)
      for (int c = 0; c < NC; c++)
        if (o_dac_en[c]) trans_cnt[c] <= trans_cnt[c] + 1;
    if (o_precharge_n && o_dac_data != '0 && prev_dac == '0)
      trial_log.push_back(o_dac_data);
    prev_dac <= o_dac_data;
  end

  always_comb begin
    int d;
    logic [1:0] idx;
    d = 0;
    idx = 2'd0;
    i_tempdelay = '0;
    for (int c = 0; c < NC; c++) begin
      d = trans_cnt[c] - base[c];
      idx = (d > 0) ? 2'(((d - 1) / NV) % 4) : 2'd0;
      i_tempdelay[c] = (o_dac_data <= thr_cur[c][idx]);
    end
  end

  typedef struct packed {
    logic [1:0]      mask;
    logic [3:0][5:0] thr0;
    logic [3:0][5:0] thr1;
    logic [4:0]      stall;
    logic [5:0]      exp0;
    logic [5:0]      exp1;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [5:0] avg4(input logic [3:0][5:0] t);
    int s;
    s = int'(t[0]) + int'(t[1]) + int'(t[2]) + int'(t[3]);
    return 6'(s / 4);
  endfunction

  task automatic do_scan(input logic [1:0] mask, input logic [3:0][5:0] t0,
                         input logic [3:0][5:0] t1, input int stall,
                         input logic [5:0] e0, input logic [5:0] e1, input bit poke);
    int  t;
    bit  first;
    logic [5:0] e;
    thr_cur[0] = t0;
    thr_cur[1] = t1;
    base[0] = trans_cnt[0];
    base[1] = trans_cnt[1];
    first = 1'b1;
    tick();
    i_ch_mask = mask;
    i_start = 1'b1;
    i_ready = 1'b0;
    tick();
    i_start = 1'b0;
    t = 1;
    chk("busy_after_start", o_busy, 1);
    for (int c = 0; c < NC; c++) begin
      if (mask[c]) begin
        while (!o_valid && t < 2000) begin
          if (poke && t == 10) begin
            i_start = 1'b1;
            i_ch_mask = 2'b11;
          end else if (poke && t == 11) begin
            i_start = 1'b0;
          end
          tick();
          t++;
        end
        chk("valid_seen", o_valid, 1);
        if (first) chk("first_valid_cycle", t, 97);
        first = 1'b0;
        e = (c == 0) ? e0 : e1;
        chk("res", o_res, e);
        chk("res_ch", o_res_ch, c);
        for (int s = 0; s < stall; s++) begin
          tick();
          chk("stall_valid", o_valid, 1);
          chk("stall_res", o_res, e);
          chk("stall_ch", o_res_ch, c);
          chk("stall_en", o_dac_en, 0);
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("valid_drop", o_valid, 0);
        if (c == 0 && mask[1]) begin
          chk("next_pre_en", o_dac_en, 2'b10);
          chk("next_pre_prech", o_precharge_n, 0);
        end
      end
    end
    if (!i_cont) chk("idle_after_scan", o_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][5:0] r0, r1;
    logic [1:0]      m;
    int              n, lb;
    logic [5:0]      exp_trials [6];
    exp_trials = '{6'd32, 6'd48, 6'd40, 6'd36, 6'd38, 6'd37};

    vecs[0] = '{2'b01, {4{6'd37}}, {4{6'd0}},  5'd0,  6'd37, 6'd0};
    vecs[1] = '{2'b01, {6'd11, 6'd10, 6'd11, 6'd10}, {4{6'd0}}, 5'd1, 6'd10, 6'd0};
    vecs[2] = '{2'b11, {4{6'd5}},  {4{6'd60}}, 5'd10, 6'd5,  6'd60};
    vecs[3] = '{2'b01, {4{6'd63}}, {4{6'd0}},  5'd2,  6'd63, 6'd0};
    vecs[4] = '{2'b10, {4{6'd0}},  {4{6'd0}},  5'd0,  6'd0,  6'd0};
    vecs[5] = '{2'b11, {4{6'd0}},  {4{6'd63}}, 5'd0,  6'd0,  6'd63};

    thr_cur[0] = '0;
    thr_cur[1] = '0;
    base[0] = 0;
    base[1] = 0;
    reset_n = 1'b0;
    i_start = 1'b0;
    i_cont = 1'b0;
    i_ready = 1'b0;
    i_ch_mask = '0;
    repeat (3) tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_dac", o_dac_data, 63);
    chk("rst_prech", o_precharge_n, 0);
    chk("rst_en", o_dac_en, 0);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("idle_hold_busy", o_busy, 0);

    for (int i = 0; i < 6; i++) begin
      lb = trial_log.size();
      do_scan(vecs[i].mask, vecs[i].thr0, vecs[i].thr1, int'(vecs[i].stall),
              vecs[i].exp0, vecs[i].exp1, 1'b0);
      if (i == 0)
        for (int k = 0; k < 6; k++) chk("trial_seq", trial_log[lb + k], exp_trials[k]);
    end

    // start with empty mask is ignored
    tick();
    i_ch_mask = 2'b00;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("mask0_busy", o_busy, 0);
    tick();
    chk("mask0_busy2", o_busy, 0);
    chk("mask0_en", o_dac_en, 0);

    // start while busy has no effect
    do_scan(2'b01, {4{6'd20}}, {4{6'd0}}, 0, 6'd20, 6'd0, 1'b1);

    for (int r = 0; r < 20; r++) begin
      m = 2'($urandom_range(1, 3));
      for (int j = 0; j < 4; j++) begin
        r0[j] = 6'($urandom_range(0, 63));
        r1[j] = 6'($urandom_range(0, 63));
      end
      do_scan(m, r0, r1, $urandom_range(0, 3), avg4(r0), avg4(r1), 1'b0);
    end

    // asynchronous reset in the middle of a measurement
    do_scan(2'b10, {4{6'd0}}, {4{6'd37}}, 0, 6'd0, 6'd37, 1'b0);
    tick();
    thr_cur[0] = {4{6'd37}};
    i_ch_mask = 2'b01;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    while (!(o_precharge_n && o_dac_data != '0) && n < 20) begin
      tick();
      n++;
    end
    chk("reached_meas", o_precharge_n, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_busy", o_busy, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_dac", o_dac_data, 63);
    chk("arst_prech", o_precharge_n, 0);
    chk("arst_en", o_dac_en, 0);
    chk("arst_res", o_res, 0);
    chk("arst_res_ch", o_res_ch, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_busy", o_busy, 0);
      chk("post_rst_en", o_dac_en, 0);
    end

    // continuous mode: rescan after the gap, then drop i_cont inside the gap
    i_cont = 1'b1;
    do_scan(2'b01, {4{6'd44}}, {4{6'd0}}, 0, 6'd44, 6'd0, 1'b0);
    chk("gap_busy", o_busy, 1);
    chk("gap_en", o_dac_en, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("gap_en_hold", o_dac_en, 0);
      chk("gap_busy_hold", o_busy, 1);
    end
    tick();
    chk("rescan_pre_en", o_dac_en, 2'b01);
    chk("rescan_pre_prech", o_precharge_n, 0);
    n = 0;
    while (!o_valid && n < 2000) begin
      tick();
      n++;
    end
    chk("rescan_valid", o_valid, 1);
    chk("rescan_res", o_res, 44);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    tick();
    chk("gap2_busy", o_busy, 1);
    i_cont = 1'b0;
    tick();
    chk("cont_drop_idle", o_busy, 0);
    chk("cont_drop_en", o_dac_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/tempsense_sar_ctrl.md
# tempsense_sar_ctrl

Multi-channel successive-approximation controller for the digitally-controlled delay-line temperature sensors. It replaces the linear DAC sweep with an MSB-first binary search, which takes N_VDAC trials per conversion. It averages 2**N_AVG conversions per channel and scans a mask-selected set of up to N_CH sensor instances. Each channel's result goes out over a valid/ready handshake to the downstream display, calibration or readout logic.

## Interface
Parameters:
- N_VDAC, 6: DAC resolution in bits, and the width of the result.
- N_CH, 2: number of sensor channels (1..8).
- N_AVG, 2: log2 of the number of conversions averaged per channel (0..4).
- GAP_CYCLES, 1024: idle cycles between scans in continuous mode (≥1).
- CH_W, derived: channel index width, max(1, clog2(N_CH)).

Ports:
- clk, in, 1: the block's single clock.
- reset_n, in, 1: asynchronous, active-low reset.
- i_start, in, 1: single-cycle request to begin a scan; sampled only in IDLE.
- i_cont, in, 1: continuous mode; after a scan, wait GAP_CYCLES and rescan.
- i_ch_mask, in, N_CH: channels to convert; latched when a scan starts.
- i_tempdelay, in, N_CH: delay-line outputs, one per channel.
- o_dac_data, out, N_VDAC: DAC code driven to all sensors.
- o_dac_en, out, N_CH: one-hot enable for the active sensor.
- o_precharge_n, out, 1: sensor precharge control, shared by all sensors.
- o_res, out, N_VDAC: averaged result.
- o_res_ch, out, CH_W: channel index belonging to o_res.
- o_valid, out, 1: result valid.
- i_ready, in, 1: downstream accepts the result.
- o_busy, out, 1: high in every state except IDLE.

## Operation
States: IDLE, PRE, TRANS, MEAS, EVAL, OUT, GAP.

IDLE:
- Outputs: o_dac_en=0, o_dac_data=all-ones, o_precharge_n=0.
- If i_start=1 and i_ch_mask≠0: latch the mask, select the lowest set channel, clear code/acc/count, go to PRE.
- If i_start=1 and i_ch_mask=0: ignore the request and stay in IDLE.

Bit trial k, from MSB to LSB, with trial = code | (1<<k). Each trial takes four states:
- PRE: dac=all-ones, precharge_n=0.
- TRANS: dac=0, precharge_n=1.
- MEAS: dac=trial, precharge_n=1.
- EVAL: dac=trial, precharge_n=1. Sample i_tempdelay[ch]; if 1, code←trial, otherwise code is unchanged.
- o_dac_en[ch]=1 in PRE, TRANS, MEAS and EVAL only.

Conversion and averaging:
- After the LSB EVAL, acc←acc+final code. acc is N_VDAC+N_AVG bits wide and cannot overflow.
- When count reaches 2**N_AVG, go to OUT. Otherwise clear code and go to PRE.

OUT:
- o_res = acc >> N_AVG (truncating); o_res_ch = ch; o_valid=1; sensor disabled.
- o_res and o_res_ch stay stable until the transfer completes.
- On valid&&ready: go to PRE for the next set mask bit above ch. If none remain, go to GAP when i_cont=1, otherwise to IDLE.

GAP:
- Counts GAP_CYCLES, then starts a new scan with a fresh copy of i_ch_mask.
- If that mask is 0, go to IDLE.
- If i_cont is low in any GAP cycle, go to IDLE on the next cycle.

Other rules:
- i_start is ignored while o_busy=1.
- i_tempdelay is sampled directly in EVAL, with no synchronizer; the sensor timing is referenced to clk.
- Unselected channels' i_tempdelay bits are don't-care.

## Timing
- Reset (asynchronous, immediate, also mid-conversion): state=IDLE, o_dac_en=0, o_dac_data=all-ones, o_precharge_n=0, o_res=0, o_res_ch=0, o_valid=0, o_busy=0, internal counters and acc=0.
- i_start accepted at cycle 0: PRE and o_busy=1 at cycle 1.
- First o_valid rises at cycle 1+4·N_VDAC·2**N_AVG; with the defaults that is cycle 97.
- When ready=1, o_valid is high for exactly one cycle and the next channel's PRE follows in the next cycle.
- Each cycle ready=0 extends OUT by one cycle; no sensor activity occurs during the stall.
- Continuous mode: the next scan's PRE comes GAP_CYCLES+1 cycles after the last transfer.

## Test plan
- Reset: assert reset_n=0 mid-MEAS → all outputs take their reset values in the same cycle with no clock edge; after release, IDLE holds until i_start.
- Single channel: N_CH=1; model tempdelay=1 iff dac_data≤37; pulse i_start → o_valid at cycle 97 with o_res=37 and o_res_ch=0; DAC trial sequence 32,48,40,36,38,37.
- Averaging truncation: model threshold alternates 10,11,10,11 across conversions → sum 42, o_res=10.
- Two channels with back-pressure: mask=2'b11, thresholds ch0=5 and ch1=60, i_ready low for 10 cycles → o_res=5/ch0 held stable for 11 cycles, then ch1 PRE next cycle, then o_res=60/ch1.
- Extremes and ignores: tempdelay always 1 → 63; always 0 → 0; i_start with mask=0 → o_busy stays 0; i_start while busy → no effect.
- Continuous mode: i_cont=1, GAP_CYCLES=4 → second scan's PRE comes 5 cycles after the final transfer; dropping i_cont during GAP → IDLE next cycle, o_busy=0.
